// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: mode/data/burst controls in, contents and status out.
// The master side drives control and data; the slave side (the register) returns q and status.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic             start;
    logic [CNT_W-1:0] shift_cnt;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, d, sin, start, shift_cnt,
        input  q, sout, busy, done
    );

    modport slave (
        input  en, mode, d, sin, start, shift_cnt,
        output q, sout, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold/load/shift/rotate/clear, plus a burst
// engine that repeats a captured shift/rotate op shift_cnt times.
//
//  state | meaning
//  IDLE  | mode ops apply on en; a valid start captures the op and count
//  RUN   | captured op applied on each en edge, count decrements; busy=1
//  DONE  | one-cycle done pulse; mode ops apply on en; returns to IDLE
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic            clk,
    input logic            rstn,
    univ_shift_reg_if.slave bus
);
    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic             sout_r, sout_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic [2:0]       op_r, op_nxt;
    logic [2:0]       apply_op;
    logic             do_apply;
    logic             start_ok;

    assign start_ok = bus.start && (bus.shift_cnt != '0) &&
                      (bus.mode inside {M_SHL, M_SHR, M_ROL, M_ROR});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            q_r    <= RST_VAL;
            sout_r <= 1'b0;
            cnt_r  <= '0;
            op_r   <= M_HOLD;
        end else begin
            state  <= state_nxt;
            q_r    <= q_nxt;
            sout_r <= sout_nxt;
            cnt_r  <= cnt_nxt;
            op_r   <= op_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_r;
        op_nxt    = op_r;
        apply_op  = bus.mode;
        do_apply  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.en) begin
                    if (start_ok) begin
                        op_nxt    = bus.mode;
                        cnt_nxt   = bus.shift_cnt;
                        state_nxt = RUN;
                    end else begin
                        do_apply = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.en) begin
                    do_apply = 1'b1;
                    apply_op = op_r;
                    if (cnt_r != '0) begin
                        cnt_nxt = cnt_r - CNT_W'(1);
                    end
                    if (cnt_r <= CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                do_apply  = bus.en;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: the selected op (live mode or captured burst op) acting on q/sout.
    always_comb begin
        q_nxt    = q_r;
        sout_nxt = sout_r;
        if (do_apply) begin
            case (apply_op)
                M_HOLD: q_nxt = q_r;
                M_LOAD: q_nxt = bus.d;
                M_SHL: begin
                    q_nxt    = {q_r[WIDTH-2:0], bus.sin};
                    sout_nxt = q_r[WIDTH-1];
                end
                M_SHR: begin
                    q_nxt    = {bus.sin, q_r[WIDTH-1:1]};
                    sout_nxt = q_r[0];
                end
                M_ROL: begin
                    q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    sout_nxt = q_r[WIDTH-1];
                end
                M_ROR: begin
                    q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
                    sout_nxt = q_r[0];
                end
                default: q_nxt = RST_VAL;
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.sout = sout_r;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, CNT_W=4, RST_VAL=0).
// Inputs change #1 after a rising edge; outputs are checked #1 after the edge.
module tb_univ_shift_reg;
    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                           ROL = 3'b100, ROR = 3'b101, CLR = 3'b110, CLR2 = 3'b111;

    logic clk = 1'b0;
    logic rstn;
    int   tests_run = 0;
    int   tests_failed = 0;

    univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

    univ_shift_reg #(.WIDTH(8), .CNT_W(4), .RST_VAL(8'h00)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic [7:0] dv, input logic s);
        bus.en    = 1'b1;
        bus.mode  = m;
        bus.d     = dv;
        bus.sin   = s;
        bus.start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rstn          = 1'b1;
        bus.en        = 1'b0;
        bus.mode      = HOLD;
        bus.d         = 8'h00;
        bus.sin       = 1'b0;
        bus.start     = 1'b0;
        bus.shift_cnt = 4'd0;
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if ({bus.q, bus.sout, bus.busy, bus.done} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_async: got q=%h sout=%b busy=%b done=%b, want 00 0 0 0",
                     bus.q, bus.sout, bus.busy, bus.done);
        end
        step();
        rstn     = 1'b1;
        bus.en   = 1'b0;
        bus.mode = LOAD;
        bus.d    = 8'hA5;
        step();
        tests_run++;
        if (bus.q !== 8'h00) begin
            tests_failed++;
            $display("FAIL stall_load: got q=%h, want 00", bus.q);
        end
    endtask

    task automatic test_shift();
        drive(LOAD, 8'hA5, 1'b0);
        tests_run++;
        if (bus.q !== 8'hA5) begin
            tests_failed++;
            $display("FAIL load: got q=%h, want a5", bus.q);
        end
        drive(SHL, 8'h00, 1'b1);
        tests_run++;
        if ({bus.q, bus.sout} !== {8'h4B, 1'b1}) begin
            tests_failed++;
            $display("FAIL shl: got q=%h sout=%b, want 4b 1", bus.q, bus.sout);
        end
        drive(SHR, 8'h00, 1'b0);
        tests_run++;
        if ({bus.q, bus.sout} !== {8'h25, 1'b1}) begin
            tests_failed++;
            $display("FAIL shr: got q=%h sout=%b, want 25 1", bus.q, bus.sout);
        end
        drive(HOLD, 8'hFF, 1'b1);
        tests_run++;
        if ({bus.q, bus.sout} !== {8'h25, 1'b1}) begin
            tests_failed++;
            $display("FAIL hold: got q=%h sout=%b, want 25 1", bus.q, bus.sout);
        end
    endtask

    task automatic test_rotate_clear();
        drive(LOAD, 8'h81, 1'b0);
        drive(ROL, 8'h00, 1'b0);
        tests_run++;
        if ({bus.q, bus.sout} !== {8'h03, 1'b1}) begin
            tests_failed++;
            $display("FAIL rol: got q=%h sout=%b, want 03 1", bus.q, bus.sout);
        end
        drive(ROR, 8'h00, 1'b0);
        tests_run++;
        if ({bus.q, bus.sout} !== {8'h81, 1'b1}) begin
            tests_failed++;
            $display("FAIL ror: got q=%h sout=%b, want 81 1", bus.q, bus.sout);
        end
        drive(CLR, 8'hFF, 1'b1);
        tests_run++;
        if ({bus.q, bus.sout} !== {8'h00, 1'b1}) begin
            tests_failed++;
            $display("FAIL clr: got q=%h sout=%b, want 00 1", bus.q, bus.sout);
        end
        drive(LOAD, 8'h5A, 1'b0);
        drive(CLR2, 8'hFF, 1'b0);
        tests_run++;
        if (bus.q !== 8'h00) begin
            tests_failed++;
            $display("FAIL clr_111: got q=%h, want 00", bus.q);
        end
    endtask

    // ROL burst of 3 from 0x01; stall_a/stall_b are burst-cycle indices with en=0 (-1 = none).
    task automatic run_burst(input string tag, input int stall_a, input int stall_b,
                             input int want_busy);
        int busy_cycles;
        drive(LOAD, 8'h01, 1'b0);
        bus.mode      = ROL;
        bus.start     = 1'b1;
        bus.shift_cnt = 4'd3;
        step();
        tests_run++;
        if ({bus.q, bus.busy} !== {8'h01, 1'b1}) begin
            tests_failed++;
            $display("FAIL %s_start: got q=%h busy=%b, want 01 1", tag, bus.q, bus.busy);
        end
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 20) begin
            bus.en    = !(busy_cycles == stall_a || busy_cycles == stall_b);
            bus.mode  = LOAD;
            bus.d     = 8'hFF;
            bus.start = ~bus.start;
            busy_cycles++;
            step();
        end
        tests_run++;
        if (busy_cycles !== want_busy) begin
            tests_failed++;
            $display("FAIL %s_busy_len: got %0d cycles, want %0d", tag, busy_cycles, want_busy);
        end
        tests_run++;
        if ({bus.q, bus.sout, bus.done} !== {8'h08, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL %s_end: got q=%h sout=%b done=%b, want 08 0 1",
                     tag, bus.q, bus.sout, bus.done);
        end
        drive(HOLD, 8'h00, 1'b0);
        tests_run++;
        if ({bus.q, bus.busy, bus.done} !== {8'h08, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL %s_after: got q=%h busy=%b done=%b, want 08 0 0",
                     tag, bus.q, bus.busy, bus.done);
        end
    endtask

    task automatic test_burst();
        run_burst("burst", -1, -1, 3);
    endtask

    task automatic test_burst_stall();
        run_burst("stall", 1, 2, 5);
    endtask

    task automatic test_abort_and_ignore();
        bit saw_done;
        drive(LOAD, 8'h01, 1'b0);
        bus.mode      = ROL;
        bus.start     = 1'b1;
        bus.shift_cnt = 4'd5;
        step();
        bus.start = 1'b0;
        step();
        step();
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if ({bus.q, bus.busy, bus.done} !== {8'h00, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL abort: got q=%h busy=%b done=%b, want 00 0 0",
                     bus.q, bus.busy, bus.done);
        end
        step();
        rstn     = 1'b1;
        bus.mode = HOLD;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got status activity=1, want 0");
        end
        drive(LOAD, 8'h01, 1'b0);
        bus.mode      = ROL;
        bus.start     = 1'b1;
        bus.shift_cnt = 4'd0;
        step();
        tests_run++;
        if ({bus.q, bus.busy} !== {8'h02, 1'b0}) begin
            tests_failed++;
            $display("FAIL zero_cnt: got q=%h busy=%b, want 02 0", bus.q, bus.busy);
        end
        bus.mode      = LOAD;
        bus.d         = 8'h3C;
        bus.shift_cnt = 4'd3;
        step();
        tests_run++;
        if ({bus.q, bus.busy} !== {8'h3C, 1'b0}) begin
            tests_failed++;
            $display("FAIL load_start: got q=%h busy=%b, want 3c 0", bus.q, bus.busy);
        end
        bus.start = 1'b0;
        step();
        tests_run++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL load_start_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    // SHR burst of 2 with sin=1 from 0x3C, then a start during DONE that must be ignored.
    task automatic test_back_to_back();
        drive(LOAD, 8'h3C, 1'b1);
        bus.mode      = SHR;
        bus.start     = 1'b1;
        bus.shift_cnt = 4'd2;
        step();
        bus.start = 1'b0;
        step();
        step();
        tests_run++;
        if ({bus.q, bus.sout, bus.done} !== {8'hCF, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL shr_burst: got q=%h sout=%b done=%b, want cf 0 1",
                     bus.q, bus.sout, bus.done);
        end
        bus.mode  = HOLD;
        bus.start = 1'b1;
        bus.shift_cnt = 4'd2;
        step();
        bus.start = 1'b0;
        tests_run++;
        if ({bus.q, bus.busy, bus.done} !== {8'hCF, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL start_in_done: got q=%h busy=%b done=%b, want cf 0 0",
                     bus.q, bus.busy, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_rotate_clear();
        test_burst();
        test_burst_stall();
        test_abort_and_ignore();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
